// File: rtl/sample_unpacker_n_pkg.sv
// sample_unpacker_n_pkg
// Shared sizing helpers and mask arithmetic for the sample unpacker.
//   unpack_depth  : sample buffer capacity for a given word/channel geometry
//   level_width   : width of a counter that can hold 0..depth
//   popcount      : number of enabled channels in a mask
//   channel_rank  : position of channel c among the enabled channels
package sample_unpacker_n_pkg;

  localparam int MAX_CHANNELS     = 32;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_IN_SAMPLES   = 4;
  localparam int DEF_NUM_CHANNELS = 4;

  // One full input word can always land on top of a residue of up to
  // NUM_CHANNELS-1 samples plus one already-accepted word.
  function automatic int unpack_depth(input int in_samples, input int num_channels);
    return 2 * in_samples + num_channels - 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEPTH   = unpack_depth(DEF_IN_SAMPLES, DEF_NUM_CHANNELS);
  localparam int LEVEL_W = level_width(DEPTH);

  function automatic int popcount(input logic [MAX_CHANNELS-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < MAX_CHANNELS; i++)
      if (mask[i]) n++;
    return n;
  endfunction

  // Number of enabled channels with an index below c.
  function automatic int channel_rank(input logic [MAX_CHANNELS-1:0] mask, input int c);
    int r;
    r = 0;
    for (int i = 0; i < MAX_CHANNELS; i++)
      if (i < c && mask[i]) r++;
    return r;
  endfunction

endpackage

// File: rtl/sample_unpacker_n_if.sv
// sample_unpacker_n_if
// Input word stream and output channel-set stream of the unpacker.
//   data_in / data_in_valid / data_in_ready    : packed input words, sample 0 in LSBs
//   data_out / data_out_valid / data_out_ready : one sample per channel, channel c at [c*SW +: SW]
// master: the environment (source and sink); slave: the unpacker.
interface sample_unpacker_n_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int IN_SAMPLES   = 4,
  parameter int NUM_CHANNELS = 4
);
  logic [IN_SAMPLES*SAMPLE_WIDTH-1:0]   data_in;
  logic                                 data_in_valid;
  logic                                 data_in_ready;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_out;
  logic                                 data_out_valid;
  logic                                 data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/sample_unpacker_n_buffer.sv
// unpack_sample_buffer
// Circular sample store: appends IN_SAMPLES samples per write, exposes the
// NUM_CHANNELS oldest samples combinationally and drops rd_count of them per read.
//   clear      : synchronous empty (pointers and level to 0), overrides wr/rd
//   wr_en      : append wr_data (sample 0 first)
//   rd_en      : remove rd_count oldest samples
//   rd_data    : oldest samples, oldest in the LSBs
//   level      : samples currently stored
//   level_next : level after this cycle's clear/write/read
module unpack_sample_buffer
  import sample_unpacker_n_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int IN_SAMPLES   = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 11,
  parameter int LVL_W        = 4
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 clear,
  input  logic                                 wr_en,
  input  logic [IN_SAMPLES*SAMPLE_WIDTH-1:0]   wr_data,
  input  logic                                 rd_en,
  input  logic [LVL_W-1:0]                     rd_count,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0]                     level,
  output logic [LVL_W-1:0]                     level_next
);
  localparam int SW    = SAMPLE_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);

  logic [SW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level_q;

  // base < DEPTH and off <= DEPTH, so one conditional subtract is enough.
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    if (clear)
      level_next = '0;
    else
      level_next = LVL_W'(int'(level_q) + (wr_en ? IN_SAMPLES : 0) - (rd_en ? int'(rd_count) : 0));
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      rd_data[c*SW +: SW] = mem[wrap(rd_ptr, c)];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear)
      for (int i = 0; i < IN_SAMPLES; i++)
        mem[wrap(wr_ptr, i)] <= wr_data[i*SW +: SW];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wrap(wr_ptr, IN_SAMPLES);
      if (rd_en) rd_ptr <= wrap(rd_ptr, int'(rd_count));
      level_q <= level_next;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sample_unpacker_n.sv
// sample_unpacker_n
// Splits packed input words into per-channel output beats for the channels
// enabled in a latched mask, in stream order, with backpressure both ways.
//   clk, resetn  : clock, asynchronous active-low reset
//   enable_mask  : channel enables, sampled when idle or on flush
//   flush        : synchronous clear of buffer and output register
//   bus          : input word stream and output channel-set stream
//   buf_level    : samples currently buffered
module sample_unpacker_n
  import sample_unpacker_n_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = 16,
  parameter  int IN_SAMPLES   = 4,
  parameter  int NUM_CHANNELS = 4,
  localparam int DEPTH        = unpack_depth(IN_SAMPLES, NUM_CHANNELS),
  localparam int LVL_W        = level_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CHANNELS-1:0] enable_mask,
  input  logic                    flush,
  sample_unpacker_n_if.slave      bus,
  output logic [LVL_W-1:0]        buf_level
);
  localparam int SW = SAMPLE_WIDTH;

  logic [NUM_CHANNELS-1:0]    mask_q;
  logic [LVL_W-1:0]           n_en;
  logic [LVL_W-1:0]           level;
  logic [LVL_W-1:0]           level_next;
  logic [NUM_CHANNELS*SW-1:0] rd_data;
  logic [NUM_CHANNELS*SW-1:0] steer;
  logic [NUM_CHANNELS*SW-1:0] data_out_q;
  logic                       out_valid_q;
  logic                       in_ready_q;
  logic                       push;
  logic                       pop;
  logic                       wr_en;
  logic                       idle;

  assign n_en  = LVL_W'(popcount(MAX_CHANNELS'(mask_q)));
  assign idle  = (level == '0) && !out_valid_q;
  assign push  = bus.data_in_valid && in_ready_q;
  // With no channel enabled, accepted words are simply dropped.
  assign wr_en = push && !flush && (mask_q != '0);
  // pop looks at pre-push contents; the freshly written word is not visible yet.
  assign pop   = !flush && (n_en != '0) && (level >= n_en) &&
                 (!out_valid_q || bus.data_out_ready);

  unpack_sample_buffer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .IN_SAMPLES   (IN_SAMPLES),
    .NUM_CHANNELS (NUM_CHANNELS),
    .DEPTH        (DEPTH),
    .LVL_W        (LVL_W)
  ) u_buffer (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (flush),
    .wr_en      (wr_en),
    .wr_data    (bus.data_in),
    .rd_en      (pop),
    .rd_count   (n_en),
    .rd_data    (rd_data),
    .level      (level),
    .level_next (level_next)
  );

  // k-th oldest sample goes to the enabled channel of rank k.
  always_comb begin
    steer = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (mask_q[c])
        steer[c*SW +: SW] = rd_data[channel_rank(MAX_CHANNELS'(mask_q), c)*SW +: SW];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      if (flush) begin
        mask_q      <= enable_mask;
        out_valid_q <= 1'b0;
        data_out_q  <= '0;
      end else begin
        if (idle) mask_q <= enable_mask;
        if (pop) begin
          data_out_q  <= steer;
          out_valid_q <= 1'b1;
        end else if (bus.data_out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
      // Registered from the next level so ready never depends on data_out_ready
      // in the same cycle; room for a full word is guaranteed when high.
      in_ready_q <= (level_next <= LVL_W'(DEPTH - IN_SAMPLES));
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.data_in_ready  = in_ready_q;
  assign buf_level          = level;

endmodule

// File: doc/sample_unpacker_n.md
Name: sample_unpacker_n

Overview:
- Parametrised successor to the fixed 64-bit/4-channel unpacker in the util_upack2_timestamp path.
- Takes wide words of IN_SAMPLES packed samples on a valid/ready stream and distributes them in stream order to the channels set in a per-channel enable mask.
- Emits one full channel set per output beat, with backpressure on both sides.
- Sits between the DMA-side FIFO and the per-channel DAC sample interface.

Parameters:
- SAMPLE_WIDTH, 16, bits per sample.
- IN_SAMPLES, 4, samples per input word.
- NUM_CHANNELS, 4, number of output channels.
- DEPTH (localparam), 2*IN_SAMPLES+NUM_CHANNELS-1, sample buffer capacity.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable_mask  in  NUM_CHANNELS  channel enables; bit c enables channel c.
- flush  in  1  synchronous clear of buffer and output register; reloads the mask.
- data_in  in  IN_SAMPLES*SAMPLE_WIDTH  packed samples; sample 0 in the LSBs.
- data_in_valid  in  1  input word valid.
- data_in_ready  out  1  block can accept a word.
- data_out  out  NUM_CHANNELS*SAMPLE_WIDTH  channel c in bits [c*SW +: SW].
- data_out_valid  out  1  output beat valid.
- data_out_ready  in  1  sink accepts the beat.
- buf_level  out  clog2(DEPTH+1)  samples currently buffered.

Behaviour:
- Reset (resetn=0, asynchronous):
  - data_out=0, data_out_valid=0, buf_level=0, data_in_ready=0.
  - mask_q=0, buffer contents don't-care.
  - Takes effect immediately, including mid-stream; all residue is lost.
- Mask latching:
  - mask_q<=enable_mask on any cycle where the block is idle: buf_level==0 and data_out_valid==0.
  - flush also latches the mask.
  - Otherwise mask_q holds. Changing enable_mask mid-stream has no effect until idle or flush.
- Enabled count: N_EN = popcount(mask_q).
- Input handshake:
  - data_in_ready = (buf_level <= DEPTH-IN_SAMPLES), registered. There is no combinational path from data_out_ready.
  - push = data_in_valid & data_in_ready. All IN_SAMPLES samples are appended in order 0..IN_SAMPLES-1.
- Output (pop):
  - pop = (N_EN!=0) & (buf_level>=N_EN) & (!data_out_valid | data_out_ready).
  - On pop, the oldest N_EN samples are removed. The k-th oldest goes to the enabled channel of rank k (ascending channel index).
  - Disabled channels get 0. data_out_valid<=1.
  - If no pop and data_out_ready=1, data_out_valid<=0.
  - data_out is held stable while valid & !ready.
- Simultaneous push and pop: buf_level_next = buf_level + (push?IN_SAMPLES:0) - (pop?N_EN:0). Pop evaluates pre-push contents.
- Latency: a word accepted in cycle t can appear on data_out in cycle t+2 (buffer write, then output register). The output register changes only on a clock edge.
- Throughput: with N_EN==IN_SAMPLES and no stalls, one output beat per cycle with data_in_ready held at 1.
- mask_q==0:
  - Words are accepted (data_in_ready=1) and discarded; buf_level stays 0.
  - No output beats.
- Residue: samples insufficient for a full set (buf_level<N_EN) remain until more input arrives or flush.
- flush:
  - Next cycle: buf_level=0, data_out_valid=0, data_out=0.
  - A push coincident with flush is dropped.
  - flush has priority over push and pop.
- Buffer: circular, with read/write pointers modulo DEPTH. Wrap-around on both pointers is required; the buffer must never over- or under-flow by construction.

Decomposition:
- Shared package/header: localparam for DEPTH, and the buf_level width via clog2.
- Shared package/header: a popcount function and a channel-rank function (rank of channel c within mask_q).
- Sub-module unpack_sample_buffer:
  - Circular sample store.
  - Writes IN_SAMPLES samples per cycle; reads up to NUM_CHANNELS consecutive samples per cycle.
  - Owns pointers and level.
- The top level owns the handshakes, mask latching and the channel steering mux.

Test Plan (SW=16, IN_SAMPLES=4, NUM_CHANNELS=4; words written {s3,s2,s1,s0}):
- mask 0001; words {4,3,2,1},{8,7,6,5}; out_ready=1 -> ch0 emits 1..8 on consecutive beats, ch1-3=0. data_in_ready drops once buf_level>8-... i.e. when buf_level>7.
- mask 1111; 8 back-to-back words of values 1..32, out_ready=1 -> beats {4,3,2,1}..{32,31,30,29}, one per cycle. First beat 2 cycles after the first accept; data_in_ready stays 1.
- mask 0111; 4 words of values 1..16 -> beats (ch0,ch1,ch2)=(1,2,3),(4,5,6),...,(13,14,15), ch3=0. buf_level ends at 1; flush then gives buf_level=0.
- mask 1010; word {4,3,2,1} -> beats ch1=1,ch3=2, then ch1=3,ch3=4; ch0=ch2=0.
- mask 1111; out_ready=0 for 5 cycles with continuous input -> data_out frozen at the first beat. data_in_ready=0 once buf_level>7; no samples lost or duplicated after release.
- resetn pulsed low mid-stream -> data_out_valid, data_out and buf_level are 0 asynchronously. The mask changed during the stream applies only after idle.
